// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the A500 expansion-bus 68000 master.
package m68k_bus_pkg;

   localparam int ADDR_W             = 23;
   localparam int DATA_W             = 16;
   localparam int BE_W               = 2;
   localparam int TIMEOUT_CYCLES_DEF = 255;
   localparam int SYNC_STAGES_DEF    = 2;

   // be[1] drives _UDS, be[0] drives _LDS
   typedef enum logic [BE_W-1:0] {
      BE_NONE  = 2'b00,
      BE_LOWER = 2'b01,
      BE_UPPER = 2'b10,
      BE_WORD  = 2'b11
   } be_e;

   typedef enum logic [3:0] {
      IDLE, ARB, S0, S1, S2, S3, S4, WAIT, S5, S6, S7, REL
   } bus_state_e;

endpackage

// File: rtl/m68k_bus_master_if.sv
// Local request port plus 68000 expansion-bus pins of the bus master.
interface m68k_bus_master_if;
   import m68k_bus_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              busy;

   logic              _BR;
   logic              _BG;
   logic              _BGACK_o;
   logic              _BGACK_i;
   logic              _AS_i;
   logic              bus_oe;
   logic [ADDR_W-1:0] A_o;
   logic              _AS_o;
   logic              _UDS_o;
   logic              _LDS_o;
   logic              RW_o;
   logic [DATA_W-1:0] D_o;
   logic              D_oe;
   logic [DATA_W-1:0] D_i;
   logic              _DTACK;
   logic              _BERR;

   modport master (
      input  req, we, addr, be, wdata,
      output rdata, ack, err, busy,
      output _BR, _BGACK_o, bus_oe, A_o, _AS_o, _UDS_o, _LDS_o, RW_o, D_o, D_oe,
      input  _BG, _BGACK_i, _AS_i, D_i, _DTACK, _BERR
   );

   modport slave (
      output req, we, addr, be, wdata,
      input  rdata, ack, err, busy,
      input  _BR, _BGACK_o, bus_oe, A_o, _AS_o, _UDS_o, _LDS_o, RW_o, D_o, D_oe,
      output _BG, _BGACK_i, _AS_i, D_i, _DTACK, _BERR
   );

endinterface

// File: rtl/sync_n.sv
// Multi-flop synchronizer for active-low asynchronous bus inputs; resets to
// the inactive (high) level so nothing looks asserted right after reset.
module sync_n #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic _RST,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain_p;

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         chain_p <= '1;
      end else begin
         chain_p[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) chain_p[i] <= chain_p[i-1];
      end
   end

   assign q = chain_p[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 expansion-bus initiator: arbitrates with _BR/_BG/_BGACK, runs one
// asynchronous read or write cycle, then releases the bus.
module m68k_bus_master
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
   input logic               CLK,
   input logic               _RST,
   m68k_bus_master_if.master bus
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > SYNC_STAGES) ? TIMEOUT_CYCLES : SYNC_STAGES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARB_SETTLE = CNT_W'(SYNC_STAGES);

   bus_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic              fail;
   logic              accept;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] wdata_q;

   logic bg_s, dtack_s, berr_s, as_s, bgack_s;

   sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bg    (.CLK(CLK), ._RST(_RST), .d(bus._BG),       .q(bg_s));
   sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dtack (.CLK(CLK), ._RST(_RST), .d(bus._DTACK),   .q(dtack_s));
   sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_berr  (.CLK(CLK), ._RST(_RST), .d(bus._BERR),    .q(berr_s));
   sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as    (.CLK(CLK), ._RST(_RST), .d(bus._AS_i),     .q(as_s));
   sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bgack (.CLK(CLK), ._RST(_RST), .d(bus._BGACK_i), .q(bgack_s));

   assign accept = (state == IDLE) && bus.req && (bus.be != BE_NONE);

   // Request fields are held from acceptance until the next acceptance, so
   // the address and write data stay stable for the whole bus cycle.
   always_ff @(posedge CLK) begin
      if (accept) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr;
         be_q    <= bus.be;
         wdata_q <= bus.wdata;
      end
   end

   assign bus.A_o = addr_q;
   assign bus.D_o = wdata_q;

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         state        <= IDLE;
         cnt          <= '0;
         fail         <= 1'b0;
         bus._BR      <= 1'b1;
         bus._BGACK_o <= 1'b1;
         bus.bus_oe   <= 1'b0;
         bus.D_oe     <= 1'b0;
         bus._AS_o    <= 1'b1;
         bus._UDS_o   <= 1'b1;
         bus._LDS_o   <= 1'b1;
         bus.RW_o     <= 1'b1;
         bus.ack      <= 1'b0;
         bus.err      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.rdata    <= '0;
      end else begin
         bus.ack <= 1'b0;
         bus.err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req && bus.be == BE_NONE) begin
                  bus.err <= 1'b1;
               end else if (accept) begin
                  bus.busy <= 1'b1;
                  bus._BR  <= 1'b0;
                  cnt      <= '0;
                  fail     <= 1'b0;
                  state    <= ARB;
               end
            end
            // Grant is only trusted once the synchronizers hold samples taken
            // after _BR went low.
            ARB: begin
               if (cnt != ARB_SETTLE) begin
                  cnt <= cnt + 1'b1;
               end else if (!bg_s && as_s && dtack_s && bgack_s) begin
                  bus._BGACK_o <= 1'b0;
                  bus._BR      <= 1'b1;
                  bus.bus_oe   <= 1'b1;
                  bus.RW_o     <= ~we_q;
                  state        <= S0;
               end
            end
            S0: state <= S1;
            S1: begin
               bus._AS_o <= 1'b0;
               if (!we_q) begin
                  bus._UDS_o <= ~be_q[1];
                  bus._LDS_o <= ~be_q[0];
               end
               state <= S2;
            end
            S2: begin
               if (we_q) bus.D_oe <= 1'b1;
               state <= S3;
            end
            S3: begin
               if (we_q) begin
                  bus._UDS_o <= ~be_q[1];
                  bus._LDS_o <= ~be_q[0];
               end
               state <= S4;
            end
            S4: begin
               cnt   <= '0;
               state <= WAIT;
            end
            // _BERR is checked ahead of _DTACK so a simultaneous pair aborts.
            WAIT: begin
               if (!berr_s || (dtack_s && cnt == TO_LAST)) begin
                  fail       <= 1'b1;
                  bus._AS_o  <= 1'b1;
                  bus._UDS_o <= 1'b1;
                  bus._LDS_o <= 1'b1;
                  state      <= S7;
               end else if (!dtack_s) begin
                  state <= S5;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S5: state <= S6;
            S6: begin
               if (!we_q) bus.rdata <= bus.D_i;
               bus._AS_o  <= 1'b1;
               bus._UDS_o <= 1'b1;
               bus._LDS_o <= 1'b1;
               state      <= S7;
            end
            S7: begin
               bus.bus_oe   <= 1'b0;
               bus.D_oe     <= 1'b0;
               bus._BGACK_o <= 1'b1;
               bus.RW_o     <= 1'b1;
               bus.ack      <= ~fail;
               bus.err      <= fail;
               state        <= REL;
            end
            REL: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed and randomized transfers against a
// phase-duration model of the bus cycle, plus reset and illegal-request cases.
module tb_m68k_bus_master;

   localparam int TO   = 8;
   localparam int SYNC = 2;

   logic        CLK = 1'b0;
   logic        _RST;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [15:0] model_rdata = '0;

   m68k_bus_master_if bus();

   m68k_bus_master #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
      .CLK (CLK),
      ._RST(_RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   function automatic int imax(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req = 0; bus.we = 0; bus.addr = '0; bus.be = 2'b00; bus.wdata = '0;
      bus.D_i = '0; bus._BG = 1; bus._BGACK_i = 1; bus._AS_i = 1;
      bus._DTACK = 1; bus._BERR = 1;
   endtask

   // k: clock after acceptance when _BG goes low (-1 = already low);
   // as_hold: extra clocks _AS_i stays low after that; d: slave delay from
   // _AS_o low to termination; mode: 0 DTACK, 1 BERR+DTACK, 2 no response.
   task automatic xfer(input logic wr, input logic [22:0] a, input logic [1:0] b,
                       input logic [15:0] wd, input logic [15:0] di, input int k,
                       input int as_hold, input int d, input int mode, input string tag);
      int r = imax(0, k) + as_hold;
      int arb = SYNC + 1 + r;
      int w = (mode == 2) ? TO : imax(1, d + SYNC - 2);
      int post = (mode == 0) ? 2 : 0;
      int n_busy = 0, n_br = 0, n_bgack = 0, n_oe = 0, n_as = 0, n_uds = 0, n_lds = 0;
      int n_doe = 0, n_ack = 0, n_err = 0, bad_a = 0, bad_rw = 0, bad_d = 0, overlap = 0;
      int first_bgack = -1, first_strb = -1, first_doe = -1, as_fall = -1, end_c = -1;
      logic [15:0] rd_at_end = 'x;
      bus._BG = (k < 0) ? 1'b0 : 1'b1;
      bus._AS_i = (as_hold > 0) ? 1'b0 : 1'b1;
      bus.req = 1; bus.we = wr; bus.addr = a; bus.be = b; bus.wdata = wd; bus.D_i = di;
      @(posedge CLK); #1;
      bus.req = 0;
      for (int c = 0; c < 200; c++) begin
         if (bus.busy) n_busy++;
         if (!bus._BR) n_br++;
         if (!bus._BGACK_o) begin n_bgack++; if (first_bgack < 0) first_bgack = c; end
         if (!bus._BR && !bus._BGACK_o) overlap++;
         if (bus.bus_oe) begin
            n_oe++;
            if (bus.A_o !== a) bad_a++;
            if (bus.RW_o !== !wr) bad_rw++;
         end
         if (!bus._AS_o) begin n_as++; if (as_fall < 0) as_fall = c; end
         if (!bus._UDS_o) n_uds++;
         if (!bus._LDS_o) n_lds++;
         if ((!bus._UDS_o || !bus._LDS_o) && first_strb < 0) first_strb = c;
         if (bus.D_oe) begin
            n_doe++;
            if (first_doe < 0) first_doe = c;
            if (bus.D_o !== wd) bad_d++;
         end
         if (bus.ack) n_ack++;
         if (bus.err) n_err++;
         if ((bus.ack || bus.err) && end_c < 0) begin end_c = c; rd_at_end = bus.rdata; end
         if (end_c >= 0 && c >= end_c + 2) break;
         if (c == k) bus._BG = 0;
         if (as_hold > 0 && c == r) bus._AS_i = 1;
         if (!bus._BGACK_o) bus._BG = 1;
         if (as_fall >= 0 && c == as_fall + d && mode != 2) begin
            bus._DTACK = 0;
            if (mode == 1) bus._BERR = 0;
         end
         if (as_fall >= 0 && bus._AS_o) begin bus._DTACK = 1; bus._BERR = 1; end
         @(posedge CLK); #1;
      end
      bus._DTACK = 1; bus._BERR = 1; bus._AS_i = 1; bus._BG = 1;
      if (mode == 0 && !wr) model_rdata = di;
      check({tag, " term"}, end_c >= 0, 1);
      check({tag, " end_at"}, end_c, arb + 6 + w + post);
      check({tag, " busy"}, n_busy, arb + 7 + w + post);
      check({tag, " ack"}, n_ack, (mode == 0) ? 1 : 0);
      check({tag, " err"}, n_err, (mode == 0) ? 0 : 1);
      check({tag, " br_low"}, n_br, arb);
      check({tag, " bgack_first"}, first_bgack, arb);
      check({tag, " bgack_low"}, n_bgack, 6 + w + post);
      check({tag, " br_bgack_overlap"}, overlap, 0);
      check({tag, " bus_oe"}, n_oe, 6 + w + post);
      check({tag, " addr_stable"}, bad_a, 0);
      check({tag, " rw"}, bad_rw, 0);
      check({tag, " as_low"}, n_as, 3 + w + post);
      check({tag, " uds_low"}, n_uds, b[1] ? (wr ? 1 + w + post : 3 + w + post) : 0);
      check({tag, " lds_low"}, n_lds, b[0] ? (wr ? 1 + w + post : 3 + w + post) : 0);
      check({tag, " strobe_first"}, first_strb, arb + (wr ? 4 : 2));
      check({tag, " doe_len"}, n_doe, wr ? 3 + w + post : 0);
      check({tag, " doe_first"}, first_doe, wr ? arb + 3 : -1);
      check({tag, " wdata"}, bad_d, 0);
      check({tag, " rdata"}, rd_at_end, model_rdata);
   endtask

   initial begin
      int acks, errs, brs, found;
      _RST = 0;
      idle_inputs();
      #12;
      check("rst _BR", bus._BR, 1);
      check("rst _BGACK_o", bus._BGACK_o, 1);
      check("rst bus_oe", bus.bus_oe, 0);
      check("rst D_oe", bus.D_oe, 0);
      check("rst strobes", {bus._AS_o, bus._UDS_o, bus._LDS_o}, 3'b111);
      check("rst RW_o", bus.RW_o, 1);
      check("rst ack_err_busy", {bus.ack, bus.err, bus.busy}, 3'b000);
      check("rst rdata", bus.rdata, 16'h0000);
      @(negedge CLK);
      _RST = 1;
      @(posedge CLK); #1;

      bus.req = 1; bus.be = 2'b00; bus.we = 0; bus.addr = 23'h000040;
      @(posedge CLK); #1;
      bus.req = 0;
      check("illegal err", bus.err, 1);
      check("illegal busy", bus.busy, 0);
      brs = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) check("illegal err_pulse", bus.err, 0);
         if (!bus._BR) brs++;
         @(posedge CLK); #1;
      end
      check("illegal no_br", brs, 0);

      xfer(0, 23'h012345, 2'b11, 16'h0000, 16'hA55A, -1, 0, 2, 0, "rd_basic");
      xfer(1, 23'h740000, 2'b10, 16'h1234, 16'h0000, -1, 0, 1, 0, "wr_upper");
      xfer(0, 23'h000100, 2'b01, 16'h0000, 16'hDEAD, -1, 0, 0, 2, "rd_timeout");
      xfer(0, 23'h000200, 2'b11, 16'h0000, 16'hBEEF, -1, 0, 1, 1, "rd_berr");
      xfer(1, 23'h000300, 2'b11, 16'hCAFE, 16'h0000, 2, 5, 0, 0, "wr_arb");
      xfer(1, 23'h7FFFFF, 2'b01, 16'h00FF, 16'h0000, 0, 0, 3, 2, "wr_timeout");

      bus._BG = 0;
      bus.req = 1; bus.we = 0; bus.be = 2'b11; bus.addr = 23'h000500; bus.D_i = 16'h5555;
      @(posedge CLK); #1;
      bus.req = 0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (!bus._AS_o) found = 1;
         else begin @(posedge CLK); #1; end
      end
      check("rstwait as_seen", found, 1);
      for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
      #2 _RST = 0;
      #1;
      check("rstwait strobes", {bus._AS_o, bus._UDS_o, bus._LDS_o}, 3'b111);
      check("rstwait bus_oe", bus.bus_oe, 0);
      check("rstwait _BGACK_o", bus._BGACK_o, 1);
      check("rstwait _BR", bus._BR, 1);
      check("rstwait busy", bus.busy, 0);
      check("rstwait ack_err", {bus.ack, bus.err}, 2'b00);
      idle_inputs();
      @(posedge CLK); @(posedge CLK); #3;
      _RST = 1;
      model_rdata = '0;
      acks = 0; errs = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK); #1;
         if (bus.ack) acks++;
         if (bus.err) errs++;
      end
      check("rstwait no_ack", acks, 0);
      check("rstwait no_err", errs, 0);
      check("rstwait rdata", bus.rdata, 16'h0000);

      for (int n = 0; n < 16; n++) begin
         logic        rw;
         logic [1:0]  rb;
         rw = 1'($urandom_range(0, 1));
         rb = 2'($urandom_range(1, 3));
         xfer(rw, 23'($urandom), rb, 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
      end

      if (n_pass + n_fail != n_checks) $fatal(1, "check bookkeeping inconsistent");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
